// File: rtl/coin_button_encoder_if.sv
// Button-to-Adder request bundle: raw buttons in, encoded one-cycle request out.
// The encoder side takes the slave modport; stimulus or board logic takes master.
interface coin_button_encoder_if;
  logic [3:0] btn;
  logic [2:0] Sig;
  logic       EA;
  logic       busy;

  modport master (
    output btn,
    input  Sig,
    input  EA,
    input  busy
  );

  modport slave (
    input  btn,
    output Sig,
    output EA,
    output busy
  );
endinterface

// File: rtl/coin_button_encoder.sv
// Sync + debounce of four buttons into one Sig/EA strobe per press; strobe lands
// DEBOUNCE_CYCLES+2 edges after first sampling, no backpressure (strobe is fire-and-forget).
module coin_button_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  coin_button_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1;
  logic [3:0]       btn_s;
  logic [3:0]       pattern;
  logic [3:0]       pattern_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  state_t           state;
  state_t           state_nxt;
  logic [2:0]       sig_q;
  logic [2:0]       sig_nxt;
  logic             ea_q;
  logic             ea_nxt;

  function automatic logic [2:0] encode(input logic [3:0] p);
    logic [2:0] c;
    c = 3'b000;
    if (p[3])      c = 3'b100;
    else if (p[2]) c = 3'b011;
    else if (p[1]) c = 3'b010;
    else if (p[0]) c = 3'b001;
    return c;
  endfunction

  // Two-flop synchroniser; the FSM never looks at the raw buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 4'b0;
      btn_s <= 4'b0;
    end else begin
      sync1 <= bus.btn;
      btn_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pattern <= 4'b0;
      sig_q   <= 3'b0;
      ea_q    <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pattern <= pattern_nxt;
      sig_q   <= sig_nxt;
      ea_q    <= ea_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pattern_nxt = pattern;
    unique case (state)
      IDLE: begin
        if (btn_s != 4'b0) begin
          pattern_nxt = btn_s;
          cnt_nxt     = '0;
          state_nxt   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        // Any change of the pressed set aborts; IDLE re-captures a new set next cycle.
        if (btn_s != pattern) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = EMIT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      EMIT: begin
        cnt_nxt   = '0;
        state_nxt = RELEASE;
      end
      RELEASE: begin
        if (btn_s != 4'b0) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered off the next state so the strobe coincides with EMIT.
  always_comb begin
    sig_nxt = 3'b0;
    ea_nxt  = 1'b1;
    if (state_nxt == EMIT) begin
      sig_nxt = encode(pattern_nxt);
      ea_nxt  = 1'b0;
    end
  end

  assign bus.Sig  = sig_q;
  assign bus.EA   = ea_q;
  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_coin_button_encoder.sv
// Directed bench for coin_button_encoder with DEBOUNCE_CYCLES=4; expected strobes
// are queued at press time and matched by a negedge monitor.
module tb_coin_button_encoder;
  localparam int DB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  typedef struct {
    logic [2:0] code;
    int         at;
  } exp_t;
  exp_t sb[$];

  coin_button_encoder_if bus();

  coin_button_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    int   pending;
    exp_t e;
    check("sig_ea_pair", {31'b0, bus.Sig != 3'b0}, {31'b0, ~bus.EA});
    if (bus.EA === 1'b0) begin
      pending = sb.size();
      check("strobe_expected", {31'b0, pending > 0}, 32'd1);
      if (pending > 0) begin
        e = sb.pop_front();
        check("strobe_code", {29'b0, bus.Sig}, {29'b0, e.code});
        if (e.at >= 0) check("strobe_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    logic [3:0] pats [3];
    logic [2:0] codes[3];
    int c;
    pats  = '{4'b0010, 4'b0100, 4'b1000};
    codes = '{3'b010, 3'b011, 3'b100};
    bus.btn = 4'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sig", {29'b0, bus.Sig}, 32'd0);
    check("rst_ea", {31'b0, bus.EA}, 32'd1);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single press, latency measured from the first sampling edge
    sb.push_back('{3'b001, cyc + DB + 3});
    bus.btn = 4'b0001;
    repeat (10) @(negedge clk);
    bus.btn = 4'b0;
    repeat (12) @(negedge clk);
    check("t1_idle", {31'b0, bus.busy}, 32'd0);

    // Each remaining button in turn
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{codes[i], cyc + DB + 3});
      bus.btn = pats[i];
      repeat (8) @(negedge clk);
      bus.btn = 4'b0;
      repeat (12) @(negedge clk);
      check("t2_idle", {31'b0, bus.busy}, 32'd0);
    end

    // Glitch shorter than the debounce window
    bus.btn = 4'b1000;
    repeat (3) @(negedge clk);
    bus.btn = 4'b0;
    repeat (12) @(negedge clk);
    check("t3_idle", {31'b0, bus.busy}, 32'd0);

    // Two buttons together, then a different set mid-debounce
    sb.push_back('{3'b011, -1});
    bus.btn = 4'b0101;
    repeat (2) @(negedge clk);
    bus.btn = 4'b0100;
    @(negedge clk);
    check("t4_busy", {31'b0, bus.busy}, 32'd1);
    repeat (10) @(negedge clk);
    bus.btn = 4'b0;
    repeat (12) @(negedge clk);
    check("t4_idle", {31'b0, bus.busy}, 32'd0);

    // Long hold with release bounces and an added button while releasing
    sb.push_back('{3'b001, cyc + DB + 3});
    bus.btn = 4'b0001;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.btn = 4'b0;
      repeat (2) @(negedge clk);
      bus.btn = (i == 2) ? 4'b1001 : 4'b0001;
      repeat (8) @(negedge clk);
    end
    bus.btn = 4'b0;
    c = cyc;
    repeat (5) @(negedge clk);
    check("t5_busy_hold", {31'b0, bus.busy}, 32'd1);
    check("t5_at_cycle", cyc, c + 5);
    @(negedge clk);
    check("t5_idle", {31'b0, bus.busy}, 32'd0);
    repeat (4) @(negedge clk);

    // Reset while debouncing
    bus.btn = 4'b0010;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("t6a_sig", {29'b0, bus.Sig}, 32'd0);
    check("t6a_ea", {31'b0, bus.EA}, 32'd1);
    check("t6a_busy", {31'b0, bus.busy}, 32'd0);
    bus.btn = 4'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);

    // Reset during the strobe cycle
    bus.btn = 4'b0100;
    repeat (DB + 3) @(posedge clk);
    #1;
    check("t6b_in_emit", {31'b0, bus.EA}, 32'd0);
    reset = 1'b0;
    #1;
    check("t6b_sig", {29'b0, bus.Sig}, 32'd0);
    check("t6b_ea", {31'b0, bus.EA}, 32'd1);
    check("t6b_busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);

    // Button still held across reset release is a fresh press
    sb.push_back('{3'b011, cyc + DB + 3});
    reset = 1'b1;
    repeat (10) @(negedge clk);
    bus.btn = 4'b0;
    repeat (12) @(negedge clk);
    check("t6c_idle", {31'b0, bus.busy}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
